// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter and one-cycle access sequencer for the data memory.
// Define DMEM_ARB_CHECK_EN to reject misaligned or out-of-range accesses with err.
module dmem_arbiter #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [31:0]       mem_readData,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    if (MEM_BYTES < 4 || (MEM_BYTES % 4) != 0) begin : g_param_chk
        $error("dmem_arbiter: MEM_BYTES must be a positive multiple of 4");
    end

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic              m0_gnt_q, m0_gnt_d;
    logic              m1_gnt_q, m1_gnt_d;
    logic              m0_done_q, m0_done_d;
    logic              m1_done_q, m1_done_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;

`ifdef DMEM_ARB_CHECK_EN
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
    logic bad_q, bad_d;
    logic err_q, err_d;
    logic sel_bad;
    assign sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Contention goes to rr_q; a lone requester always wins.
    assign pick     = (m0_req && m1_req) ? rr_q : m1_req;
    assign sel_we   = pick ? m1_we : m0_we;
    assign sel_addr = pick ? m1_addr : m0_addr;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        m0_gnt_d  = 1'b0;
        m1_gnt_d  = 1'b0;
        m0_done_d = 1'b0;
        m1_done_d = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
`ifdef DMEM_ARB_CHECK_EN
        bad_d     = bad_q;
        err_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_d    = pick;
                    rr_d     = ~pick;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = pick ? m1_wdata : m0_wdata;
                    m0_gnt_d = ~pick;
                    m1_gnt_d = pick;
                    busy_d   = 1'b1;
                    state_d  = ACCESS;
`ifdef DMEM_ARB_CHECK_EN
                    bad_d    = sel_bad;
                    wr_d     = sel_we & ~sel_bad;
                    rd_d     = ~sel_we & ~sel_bad;
`else
                    wr_d     = sel_we;
                    rd_d     = ~sel_we;
`endif
                end
            end
            ACCESS: begin
                m0_done_d = ~win_q;
                m1_done_d = win_q;
                state_d   = DONE;
`ifdef DMEM_ARB_CHECK_EN
                if (bad_q) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (!we_q) begin
                    rdata_d = mem_readData;
                end
`else
                if (!we_q) begin
                    rdata_d = mem_readData;
                end
`endif
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            m0_gnt_q  <= 1'b0;
            m1_gnt_q  <= 1'b0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
`ifdef DMEM_ARB_CHECK_EN
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            m0_gnt_q  <= m0_gnt_d;
            m1_gnt_q  <= m1_gnt_d;
            m0_done_q <= m0_done_d;
            m1_done_q <= m1_done_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
`ifdef DMEM_ARB_CHECK_EN
            bad_q     <= bad_d;
            err_q     <= err_d;
`endif
        end
    end

    assign m0_gnt        = m0_gnt_q;
    assign m1_gnt        = m1_gnt_q;
    assign m0_done       = m0_done_q;
    assign m1_done       = m1_done_q;
    assign rdata         = rdata_q;
    assign mem_address   = addr_q;
    assign mem_writeData = wdata_q;
    assign mem_memWrite  = wr_q;
    assign mem_memRead   = rd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian 128-byte memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [128] = '{default: 8'h00};

    dmem_arbiter #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done),
        .rdata(rdata), .err(err),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_readData(mem_readData), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_readData = 32'hBAD0BAD0;
        if (mem_address < 32'd125)
            mem_readData = {mem[mem_address[6:0]], mem[mem_address[6:0] + 7'd1],
                            mem[mem_address[6:0] + 7'd2], mem[mem_address[6:0] + 7'd3]};
    end

    always @(negedge clk) begin
        if (mem_memWrite && mem_address < 32'd125) begin
            mem[mem_address[6:0]]        <= mem_writeData[31:24];
            mem[mem_address[6:0] + 7'd1] <= mem_writeData[23:16];
            mem[mem_address[6:0] + 7'd2] <= mem_writeData[15:8];
            mem[mem_address[6:0] + 7'd3] <= mem_writeData[7:0];
        end
    end

    task automatic wait_idle;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy=%b required 0 within 8 cycles", busy);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done, err, mem_memRead, mem_memWrite, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {m0_gnt, m1_gnt, m0_done, m1_done, err, mem_memRead, mem_memWrite, busy});
        end
        checks++;
        if (rdata !== 32'h0 || mem_address !== 32'h0 || mem_writeData !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0",
                     rdata, mem_address, mem_writeData);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_contention;
        logic [6:0] g0, g1, d0, d1, rd;
        int ovl;
        g0 = '0; g1 = '0; d0 = '0; d1 = '0; rd = '0; ovl = 0;
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            g0[k] = m0_gnt; g1[k] = m1_gnt;
            d0[k] = m0_done; d1[k] = m1_done;
            rd[k] = mem_memRead;
            if ((mem_memRead && mem_memWrite) || (m0_gnt && m1_gnt)) ovl++;
        end
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        checks++;
        if (g0 !== 7'b1000001) begin
            errors++; $display("FAIL cont_m0_gnt: got %b required 1000001", g0);
        end
        checks++;
        if (g1 !== 7'b0001000) begin
            errors++; $display("FAIL cont_m1_gnt: got %b required 0001000", g1);
        end
        checks++;
        if (d0 !== 7'b0000010 || d1 !== 7'b0010000) begin
            errors++; $display("FAIL cont_done: got d0=%b d1=%b required 0000010 0010000", d0, d1);
        end
        checks++;
        if (rd !== 7'b1001001 || ovl !== 0) begin
            errors++; $display("FAIL cont_strobe: got rd=%b ovl=%0d required 1001001 0", rd, ovl);
        end
    endtask

    task automatic test_write_read;
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_memWrite, mem_memRead} !== 4'b1010) begin
            errors++;
            $display("FAIL wr_gnt: gnt0/gnt1/wr/rd=%b required 1010",
                     {m0_gnt, m1_gnt, mem_memWrite, mem_memRead});
        end
        checks++;
        if (mem_address !== 32'h10 || mem_writeData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_bus: addr=%h data=%h required 00000010 deadbeef",
                     mem_address, mem_writeData);
        end
        @(negedge clk);
        m0_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({m0_done, m0_gnt, mem_memWrite, mem_memRead, err} !== 5'b10000) begin
            errors++;
            $display("FAIL wr_done: done/gnt/wr/rd/err=%b required 10000",
                     {m0_done, m0_gnt, mem_memWrite, mem_memRead, err});
        end
        checks++;
        if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF || mem_address !== 32'h10) begin
            errors++;
            $display("FAIL wr_mem: mem=%h addr=%h required deadbeef 00000010",
                     {mem[16], mem[17], mem[18], mem[19]}, mem_address);
        end
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        @(posedge clk); #1;
        checks++;
        if ({m0_gnt, mem_memWrite, mem_memRead} !== 3'b101) begin
            errors++;
            $display("FAIL rd_gnt: gnt/wr/rd=%b required 101", {m0_gnt, mem_memWrite, mem_memRead});
        end
        @(negedge clk);
        m0_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m0_done !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: done=%b rdata=%h required 1 deadbeef", m0_done, rdata);
        end
    endtask

    task automatic test_isolation;
        logic [4:0] g0, g1, d0, d1, wr;
        logic [31:0] rd_at_done;
        g0 = '0; g1 = '0; d0 = '0; d1 = '0; wr = '0; rd_at_done = '0;
        wait_idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h00000011;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            g0[k] = m0_gnt; g1[k] = m1_gnt;
            d0[k] = m0_done; d1[k] = m1_done;
            wr[k] = mem_memWrite;
            if (m0_done) rd_at_done = rdata;
            @(negedge clk);
            if (m1_gnt) m1_req = 1'b0;
            if (m0_gnt) m0_req = 1'b0;
        end
        checks++;
        if (g1 !== 5'b00001 || d1 !== 5'b00010 || wr !== 5'b00001) begin
            errors++;
            $display("FAIL iso_m1: g1=%b d1=%b wr=%b required 00001 00010 00001", g1, d1, wr);
        end
        checks++;
        if (g0 !== 5'b01000 || d0 !== 5'b10000) begin
            errors++; $display("FAIL iso_m0: g0=%b d0=%b required 01000 10000", g0, d0);
        end
        checks++;
        if (rd_at_done !== 32'h00000011) begin
            errors++; $display("FAIL iso_rdata: got %h required 00000011", rd_at_done);
        end
    endtask

    task automatic test_reset_access;
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        @(posedge clk); #1;
        checks++;
        if (mem_memRead !== 1'b1) begin
            errors++; $display("FAIL rst_pre: memRead=%b required 1", mem_memRead);
        end
        #2 rst = 1'b1;
        m0_req = 1'b0;
        #1;
        checks++;
        if ({mem_memRead, mem_memWrite, m0_gnt, busy} !== 4'b0000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: rd/wr/gnt/busy=%b rdata=%h required 0000 00000000",
                     {mem_memRead, mem_memWrite, m0_gnt, busy}, rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (m0_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_nodone: done=%b busy=%b required 0 0", m0_done, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
        @(posedge clk); #1;
        checks++;
        if (m0_gnt !== 1'b1 || mem_memRead !== 1'b1) begin
            errors++; $display("FAIL rst_after_gnt: gnt=%b rd=%b required 1 1", m0_gnt, mem_memRead);
        end
        @(negedge clk);
        m0_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m0_done !== 1'b1 || rdata !== 32'h00000011) begin
            errors++;
            $display("FAIL rst_after_data: done=%b rdata=%h required 1 00000011", m0_done, rdata);
        end
    endtask

`ifdef DMEM_ARB_CHECK_EN
    task automatic test_range_check;
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h7C; m0_wdata = 32'h01020304;
        @(posedge clk); #1;
        @(negedge clk); m0_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m0_done !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL chk_ok_wr: done=%b err=%b required 1 0", m0_done, err);
        end
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h7E;
        @(posedge clk); #1;
        checks++;
        if ({m0_gnt, mem_memRead, mem_memWrite} !== 3'b100) begin
            errors++;
            $display("FAIL chk_rd_strb: gnt/rd/wr=%b required 100", {m0_gnt, mem_memRead, mem_memWrite});
        end
        @(negedge clk); m0_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m0_done !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL chk_rd_err: done=%b err=%b rdata=%h required 1 1 0", m0_done, err, rdata);
        end
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h80; m0_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        checks++;
        if ({m0_gnt, mem_memRead, mem_memWrite} !== 3'b100) begin
            errors++;
            $display("FAIL chk_wr_strb: gnt/rd/wr=%b required 100", {m0_gnt, mem_memRead, mem_memWrite});
        end
        @(negedge clk); m0_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m0_done !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL chk_wr_err: done=%b err=%b required 1 1", m0_done, err);
        end
        wait_idle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h7C;
        @(posedge clk); #1;
        @(negedge clk); m0_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || rdata !== 32'h01020304) begin
            errors++; $display("FAIL chk_reread: err=%b rdata=%h required 0 01020304", err, rdata);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_write_read();
        test_isolation();
        test_reset_access();
`ifdef DMEM_ARB_CHECK_EN
        test_range_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and access sequencer for the byte-addressed, big-endian, word-wide data memory.
- Master 0 is the pipeline MEM stage; master 1 is the debug/loader port.
- Grants one access at a time, round-robin.
- Drives the memory's memRead/memWrite strobes for exactly one full clock cycle, then returns the read word and a done pulse to the winner.

Parameters:
- MEM_BYTES, 128, memory size in bytes; used by the optional range check.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request (level)
- m0_we  in  1  master 0: 1=write, 0=read
- m0_addr  in  ADDR_W  master 0 byte address
- m0_wdata  in  32  master 0 write word
- m0_gnt  out  1  master 0 granted (1-cycle pulse)
- m0_done  out  1  master 0 access complete (1-cycle pulse)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done  same as master 0, for master 1
- rdata  out  32  read word for the completing master, held until next completion
- err  out  1  access rejected (pulses with done; optional feature only)
- mem_address  out  ADDR_W  to memory address
- mem_writeData  out  32  to memory writeData
- mem_memWrite  out  1  to memory memWrite
- mem_memRead  out  1  to memory memRead
- mem_readData  in  32  from memory readData
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; rr_ptr=0 (master 0 favoured).
  - All outputs 0: gnt, done, err, rdata, mem_memRead, mem_memWrite, mem_address, mem_writeData, busy.
- FSM states IDLE, ACCESS, DONE; one cycle each in ACCESS and DONE.
- IDLE:
  - If no request, stay.
  - If exactly one request, grant it.
  - If both request, grant the master selected by rr_ptr; rr_ptr then points at the other master.
  - Also update rr_ptr on a single-master grant.
  - At the grant edge: latch winner id, we, addr, wdata; go to ACCESS.
- ACCESS:
  - winner gnt=1.
  - mem_address and mem_writeData come from the latched values.
  - mem_memWrite=we, mem_memRead=!we (never both).
  - The memory commits writes on the negedge inside this cycle.
  - At the closing posedge: if read, rdata<=mem_readData; go to DONE.
- DONE:
  - Both strobes 0; mem_address and mem_writeData hold their last values.
  - winner done=1.
  - Next state is IDLE.
- Latency: req sampled at edge N → gnt in cycle N+1 → done and valid rdata in cycle N+2.
  - Back-to-back throughput: one access per 3 cycles.
- Requester rules:
  - A requester holds req, we, addr and wdata stable until gnt.
  - It drops req in the cycle after done; a req still high in IDLE is a new request.
  - Inputs are ignored outside IDLE.
- rdata:
  - Unchanged by writes.
  - Holds its last value until the next read completes.
- Simultaneous requests with both masters continuously asserting: grants alternate 0,1,0,1.
- A late request from the loser while the winner is in ACCESS or DONE waits; it is served at the next IDLE.
- Reset mid-ACCESS:
  - Strobes drop asynchronously; no done is issued.
  - A write whose negedge already occurred remains committed; otherwise it is dropped.
- Address arithmetic: passed through unmodified; no wrap handling in the base build.

Optional Feature:
- Macro DMEM_ARB_CHECK_EN.
- Defined:
  - At the grant edge, the latched access is flagged bad if addr[1:0]!=0 or addr > MEM_BYTES-4.
  - A bad access still passes through ACCESS, but with both strobes 0 (memory untouched).
  - In DONE: err=1 together with done, and rdata<=0.
- Undefined: no check; err is tied to 0; every access reaches memory.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 immediately; busy=0.
- Single write then read: m0 writes 0xDEADBEEF to addr 0x10; m0 then reads 0x10.
  - Write: gnt at N+1 with mem_memWrite=1 for exactly one cycle; done at N+2.
  - Read: rdata=0xDEADBEEF at done.
- Contention: m0_req and m1_req high in the same cycle after reset, both held.
  - Grant order m0, m1, m0.
  - Neither strobe overlaps another; 3 cycles per access.
- Master isolation: m1 writes 0x00000011 to 0x20 while m0 waits.
  - m0's read of 0x20 returns 0x00000011.
  - m0_done never pulses during m1's access.
- Reset in ACCESS: raise rst during a m0 read cycle → strobes drop at once, no done; the next request after reset is served normally.
- DMEM_ARB_CHECK_EN: read at 0x7E and write at 0x80 (MEM_BYTES=128).
  - Both: err=1 with done, rdata=0, mem strobes stay 0.
  - Re-read of 0x7C shows unchanged contents.
